sha256_round_stage_pipeline: RTL and testbench

SHA256_ROUND_STAGE_PIPELINE -- requirements
Module: sha256_round_stage_pipeline

---
 rtl/sha256_round_stage_pipeline.sv | 130 +++++++++++++
 tb/tb_sha256_round_stage_pipeline.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_stage_pipeline.sv
// rtl/sha256_round_stage_pipeline.sv - one SHA-256 compression round with a 2-entry skid output buffer
//
// Purpose:
//    Applies a single SHA-256 round (constant ROUND_K, word W_t = block_in[31:0])
//    to the working variables on state_in. Along with the new state, the block
//    forwards the message-schedule window without its oldest word. Each result
//    is captured into a main/skid register pair. in_ready therefore comes from
//    a flop, and throughput stays at one transaction per cycle.
//
// Ports:
//    CLK        in   1    clock, rising edge
//    RST        in   1    asynchronous active-low reset
//    in_valid   in   1    state_in/block_in carry a transaction
//    in_ready   out  1    stage accepts this cycle (registered, == !skid_full)
//    state_in   in   256  {a,b,c,d,e,f,g,h}, a in [255:224]
//    block_in   in   384  schedule window, W_t in [31:0], oldest word in [383:352]
//    out_valid  out  1    state_out/block_out carry a transaction
//    out_ready  in   1    downstream accepts this cycle
//    state_out  out  256  working variables after the round
//    block_out  out  352  block_in[351:0] of the same transaction

module sha256_round_stage_pipeline #(
   parameter logic [31:0] ROUND_K = 32'hbf597fc7
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] state_in,
   input  logic [383:0] block_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] state_out,
   output logic [351:0] block_out
);

   localparam int ENTRY_W = 608;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   buf_state_e           buf_state_q, buf_state_d;
   logic [ENTRY_W-1:0]   main_q, main_d;
   logic [ENTRY_W-1:0]   skid_q, skid_d;
   logic                 in_ready_q, in_ready_d;

   logic [31:0] a, b, c, d, e, f, g, h, w_t;
   logic [31:0] s0, s1, ch, maj, t1, t2;
   logic [ENTRY_W-1:0] round_entry;
   logic               accept, drain;

   // The oldest window word is consumed by the schedule stage upstream only.
   logic unused_oldest_word;
   assign unused_oldest_word = ^block_in[383:352];

   // Round arithmetic, purely combinational on the input transaction.
   always_comb begin
      {a, b, c, d, e, f, g, h} = state_in;
      w_t = block_in[31:0];
      s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
      s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
      ch  = (e & f) ^ (~e & g);
      maj = (a & b) ^ (a & c) ^ (b & c);
      t1  = h + s1 + ch + ROUND_K + w_t;
      t2  = s0 + maj;
      round_entry = {t1 + t2, a, b, c, d + t1, e, f, g, block_in[351:0]};
   end

   assign out_valid = (buf_state_q != BUF_EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid & in_ready_q;
   assign drain     = out_valid & out_ready;
   assign state_out = main_q[ENTRY_W-1:352];
   assign block_out = main_q[351:0];

   always_comb begin
      buf_state_d = buf_state_q;
      main_d      = main_q;
      skid_d      = skid_q;
      unique case (buf_state_q)
         BUF_EMPTY: begin
            if (accept) begin
               main_d      = round_entry;
               buf_state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (accept && drain) begin
               // Main is emptied and refilled on the same edge; skid stays unused.
               main_d = round_entry;
            end else if (accept) begin
               skid_d      = round_entry;
               buf_state_d = BUF_TWO;
            end else if (drain) begin
               buf_state_d = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            // in_ready is low here, so only a drain can change anything.
            if (drain) begin
               main_d      = skid_q;
               buf_state_d = BUF_ONE;
            end
         end
         default: begin
            buf_state_d = BUF_EMPTY;
         end
      endcase
      // Registered ready: next cycle may accept unless the skid will be occupied.
      in_ready_d = (buf_state_d != BUF_TWO);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         buf_state_q <= BUF_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b0;
      end else begin
         buf_state_q <= buf_state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_sha256_round_stage_pipeline.sv
// tb/tb_sha256_round_stage_pipeline.sv - self-checking bench for sha256_round_stage_pipeline

module tb_sha256_round_stage_pipeline;

   localparam logic [31:0] K = 32'h428a2f98;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] state_in = '0;
   logic [383:0] block_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [255:0] state_out;
   logic [351:0] block_out;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   logic [607:0] exp_q[$];

   sha256_round_stage_pipeline #(.ROUND_K(K)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .block_in  (block_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .block_out (block_out)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [607:0] model(input logic [255:0] s, input logic [383:0] blk);
      logic [31:0] v[8];
      logic [31:0] t1, t2;
      for (int i = 0; i < 8; i++) v[i] = s[255 - 32*i -: 32];
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K + blk[31:0];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      return {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6], blk[351:0]};
   endfunction

   task automatic rand_inputs();
      for (int i = 0; i < 8; i++)  state_in[32*i +: 32] = $urandom;
      for (int i = 0; i < 12; i++) block_in[32*i +: 32] = $urandom;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard: push on accept, pop and compare on drain.
   always @(negedge CLK) begin
      logic [607:0] exp;
      if (!RST) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_spurious: output with nothing expected, state_out=%h", state_out);
            end else begin
               exp = exp_q.pop_front();
               if ({state_out, block_out} !== exp) begin
                  n_fail++;
                  $display("FAIL sb_data: got %h expected %h", {state_out, block_out}, exp);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(state_in, block_in));
      end
   end

   task automatic test_reset();
      RST = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      rand_inputs();
      repeat (3) @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_checks++;
      if (state_out !== 256'd0) begin n_fail++; $display("FAIL reset_state_out: got %h expected 0", state_out); end
      n_checks++;
      if (block_out !== 352'd0) begin n_fail++; $display("FAIL reset_block_out: got %h expected 0", block_out); end
      in_valid = 1'b0;
      #1 RST = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_pre: got %b expected 0", in_ready); end
      tick();
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready_post: got %b expected 1", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_known_vector();
      logic [255:0] exp_state;
      exp_state = 256'h5d6aebcd_6a09e667_bb67ae85_3c6ef372_fa2a4622_510e527f_9b05688c_1f83d9ab;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      state_in  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
      rand_inputs_block_only();
      block_in[31:0] = 32'h61626380;
      @(negedge CLK);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kv_in_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL kv_latency: out_valid=%b expected 1", out_valid); end
      n_checks++;
      if (state_out !== exp_state) begin n_fail++; $display("FAIL kv_state: got %h expected %h", state_out, exp_state); end
      tick();
   endtask

   task automatic rand_inputs_block_only();
      for (int i = 0; i < 12; i++) block_in[32*i +: 32] = $urandom;
   endtask

   task automatic test_backpressure();
      int acc;
      logic exp_rdy;
      acc = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         rand_inputs();
         @(negedge CLK);
         exp_rdy = (i < 2);
         n_checks++;
         if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b expected %b", i, in_ready, exp_rdy); end
         if (in_valid && in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (acc != 2) begin n_fail++; $display("FAIL bp_accept_count: got %0d expected 2", acc); end
      out_ready = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready); end
      tick();
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_drain: out_valid=%b in_ready=%b expected 1 1", out_valid, in_ready); end
      tick();
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid=%b expected 0", out_valid); end
      tick();
   endtask

   task automatic test_back_to_back();
      int n0;
      logic exp_v;
      n0 = n_out;
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         in_valid = (i < 16);
         if (i < 16) rand_inputs();
         @(negedge CLK);
         exp_v = (i >= 1 && i <= 16);
         n_checks++;
         if (out_valid !== exp_v || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_cycle_%0d: out_valid=%b in_ready=%b expected %b 1", i, out_valid, in_ready, exp_v);
         end
         tick();
      end
      n_checks++;
      if (n_out - n0 != 16) begin n_fail++; $display("FAIL stream_count: got %0d expected 16", n_out - n0); end
   endtask

   task automatic test_passthrough();
      logic [351:0] exp_blk;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      rand_inputs();
      block_in[383:352] = 32'hdeadbeef;
      for (int i = 0; i < 11; i++) begin
         block_in[32*i +: 32] = 32'h1111_0000 + 32'(i * 32'h0101);
         exp_blk[32*i +: 32]  = 32'h1111_0000 + 32'(i * 32'h0101);
      end
      tick();
      in_valid = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b1 || block_out !== exp_blk) begin
         n_fail++;
         $display("FAIL passthrough: out_valid=%b block_out=%h expected %h", out_valid, block_out, exp_blk);
      end
      tick();
   endtask

   task automatic test_reset_in_two();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         rand_inputs();
         tick();
      end
      in_valid = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL two_setup: out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready); end
      tick();
      RST = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || state_out !== 256'd0) begin
         n_fail++;
         $display("FAIL two_async_reset: out_valid=%b in_ready=%b state_out=%h expected 0 0 0", out_valid, in_ready, state_out);
      end
      out_ready = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL two_stale_%0d: out_valid=%b expected 0", i, out_valid); end
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL two_ready_back: got %b expected 1", in_ready); end
      tick();
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_backpressure();
      test_back_to_back();
      test_passthrough();
      test_reset_in_two();
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d pending expected 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
